// File: rtl/key_cmd_sched.sv
// ============================================================================
// key_cmd_sched : PS/2 key codes -> per-player command FIFOs -> round-robin
// scheduled command port. Optional auto-repeat under `KEY_REPEAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_cmd_sched #(
  parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_ascii,
  output logic       cmd_valid,
  output logic       cmd_player,
  output logic [1:0] cmd_dir,
  input  logic       cmd_ready,
  output logic       ovf,
  output logic       ovf_player
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0] prev_q;

  // Codes 1..8: (code-1)[2] selects the player, (code-1)[1:0] the direction.
  logic       code_ok;
  logic [2:0] code_m1;
  logic       key_player;
  logic [1:0] key_dir;
  logic       press;
  logic       rep_fire;
  logic       ev;

  assign code_ok    = (key_ascii != 8'd0) && (key_ascii <= 8'd8);
  assign code_m1    = key_ascii[2:0] - 3'd1;
  assign key_player = code_m1[2];
  assign key_dir    = code_m1[1:0];
  assign press      = code_ok && (key_ascii != prev_q);

`ifdef KEY_REPEAT_EN
  logic [23:0] rep_cnt_q, rep_cnt_d;
  logic        rep_first_q, rep_first_d;

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (press) begin
      rep_cnt_d   = 24'd0;
      rep_first_d = 1'b0;
    end else if (code_ok) begin
      if (rep_cnt_q == (rep_first_q ? REPEAT_PERIOD : REPEAT_DELAY)) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = 24'd0;
        rep_first_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 24'd1;
      end
    end else begin
      rep_cnt_d = 24'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= 24'd0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign ev = press || rep_fire;

  logic [1:0]    mem_q [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [AW:0]   count_q  [2];

  logic [1:0] full;
  logic [1:0] nempty;
  logic [1:0] push;
  logic [1:0] pop;
  logic       load;
  logic       grant;
  logic       last_grant_q, last_grant_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       cmd_player_q, cmd_player_d;
  logic [1:0] cmd_dir_q, cmd_dir_d;
  logic       ovf_q, ovf_d;
  logic       ovf_player_q, ovf_player_d;

  assign full[0]   = (count_q[0] == DEPTH_C);
  assign full[1]   = (count_q[1] == DEPTH_C);
  assign nempty[0] = (count_q[0] != '0);
  assign nempty[1] = (count_q[1] != '0);
  assign push[0]   = ev && !key_player && !full[0];
  assign push[1]   = ev &&  key_player && !full[1];
  assign load      = !cmd_valid_q || cmd_ready;

  // Contention goes to the queue not served last; otherwise the only non-empty one.
  assign grant = (nempty[0] && nempty[1]) ? ~last_grant_q : ~nempty[0];

  always_comb begin
    pop          = 2'b00;
    last_grant_d = last_grant_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_player_d = cmd_player_q;
    cmd_dir_d    = cmd_dir_q;
    ovf_d        = ev && full[key_player];
    ovf_player_d = ovf_d ? key_player : ovf_player_q;
    if (load) begin
      if (|nempty) begin
        pop[grant]   = 1'b1;
        last_grant_d = grant;
        cmd_valid_d  = 1'b1;
        cmd_player_d = grant;
        cmd_dir_d    = mem_q[grant][rd_ptr_q[grant]];
      end else begin
        cmd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= 8'd0;
      last_grant_q <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_player_q <= 1'b0;
      cmd_dir_q    <= 2'd0;
      ovf_q        <= 1'b0;
      ovf_player_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
      end
    end else begin
      prev_q       <= key_ascii;
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_player_q <= cmd_player_d;
      cmd_dir_q    <= cmd_dir_d;
      ovf_q        <= ovf_d;
      ovf_player_q <= ovf_player_d;
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PTR_ONE;
        if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + PTR_ONE;
        count_q[p] <= count_q[p] + (push[p] ? CNT_ONE : '0) - (pop[p] ? CNT_ONE : '0);
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= key_dir;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_player = cmd_player_q;
  assign cmd_dir    = cmd_dir_q;
  assign ovf        = ovf_q;
  assign ovf_player = ovf_player_q;

endmodule

`default_nettype wire

// File: tb/tb_key_cmd_sched.sv
// ============================================================================
// tb_key_cmd_sched : scoreboard bench for key_cmd_sched (REPEAT_DELAY=10,
// REPEAT_PERIOD=4, FIFO_DEPTH=4); repeat expectations follow `KEY_REPEAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_cmd_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_ascii;
  logic       cmd_ready;
  logic       cmd_valid;
  logic       cmd_player;
  logic [1:0] cmd_dir;
  logic       ovf;
  logic       ovf_player;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [2:0] sb[$];
  int         acc_cyc[$];
  logic [2:0] mon_exp;

  key_cmd_sched #(
    .REPEAT_DELAY (24'd10),
    .REPEAT_PERIOD(24'd4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_ascii (key_ascii),
    .cmd_valid (cmd_valid),
    .cmd_player(cmd_player),
    .cmd_dir   (cmd_dir),
    .cmd_ready (cmd_ready),
    .ovf       (ovf),
    .ovf_player(ovf_player)
  );

  always #5 clk = ~clk;

  // Every accepted command is compared with the oldest expected one.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && cmd_valid && cmd_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL accept_unexpected: got p%0d d%0d, required no command", cmd_player, cmd_dir);
      end else begin
        mon_exp = sb.pop_front();
        if ({cmd_player, cmd_dir} !== mon_exp) begin
          errors++;
          $display("FAIL accept_order: got p%0d d%0d, required p%0d d%0d",
                   cmd_player, cmd_dir, mon_exp[2], mon_exp[1:0]);
        end
      end
      acc_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !cmd_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; key_ascii = 8'd0; cmd_ready = 1'b0;
    tick(3);
    checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b, required 0", cmd_valid); end
    checks++; if (cmd_player !== 1'b0) begin errors++; $display("FAIL reset_player: got %b, required 0", cmd_player); end
    checks++; if (cmd_dir !== 2'd0)    begin errors++; $display("FAIL reset_dir: got %0d, required 0", cmd_dir); end
    checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    checks++; if (ovf_player !== 1'b0) begin errors++; $display("FAIL reset_ovf_player: got %b, required 0", ovf_player); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_key;
    bit ok;
    cmd_ready = 1'b1;
    key_ascii = 8'd3;
    sb.push_back(3'b0_10);
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_latency_e0: got valid %b, required 0", cmd_valid); end
    key_ascii = 8'd0;
    tick();
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL single_latency_e1: got valid %b, required 1", cmd_valid); end
    checks++;
    if ({cmd_player, cmd_dir} !== 3'b0_10) begin
      errors++; $display("FAIL single_cmd: got p%0d d%0d, required p0 d2", cmd_player, cmd_dir);
    end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain: got timeout, required drained"); end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [7:0] codes [6] = '{8'd1, 8'd0, 8'd5, 8'd0, 8'd2, 8'd0};
    cmd_ready = 1'b0;
    foreach (codes[i]) begin
      key_ascii = codes[i];
      if (codes[i] == 8'd1) sb.push_back(3'b0_00);
      if (codes[i] == 8'd5) sb.push_back(3'b1_00);
      if (codes[i] == 8'd2) sb.push_back(3'b0_01);
      tick();
    end
    checks++;
    if (cmd_valid !== 1'b1 || {cmd_player, cmd_dir} !== 3'b0_00) begin
      errors++; $display("FAIL bp_hold: got v%b p%0d d%0d, required v1 p0 d0", cmd_valid, cmd_player, cmd_dir);
    end
    tick(3);
    checks++;
    if (cmd_valid !== 1'b1 || {cmd_player, cmd_dir} !== 3'b0_00) begin
      errors++; $display("FAIL bp_stable: got v%b p%0d d%0d, required v1 p0 d0", cmd_valid, cmd_player, cmd_dir);
    end
    cmd_ready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got timeout, required drained"); end
  endtask

  task automatic test_overflow;
    bit ok;
    int base;
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_ascii = 8'd4;
      if (i < 5) sb.push_back(3'b0_11);
      tick();
      checks++;
      if (ovf !== (i == 5)) begin
        errors++; $display("FAIL ovf_press%0d: got ovf %b, required %0d", i, ovf, (i == 5));
      end
      if (i == 5) begin
        checks++;
        if (ovf_player !== 1'b0) begin errors++; $display("FAIL ovf_player: got %b, required 0", ovf_player); end
      end
      key_ascii = 8'd0;
      tick();
      if (i == 5) begin
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %b, required 0", ovf); end
      end
    end
    base = acc_cyc.size();
    cmd_ready = 1'b1;
    wait_drain(ok);
    tick(5);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain: got timeout, required drained"); end
    checks++;
    if (acc_cyc.size() - base != 5) begin
      errors++; $display("FAIL ovf_count: got %0d commands, required 5", acc_cyc.size() - base);
    end
  endtask

  task automatic test_repeat;
    bit ok;
    int n_exp;
`ifdef KEY_REPEAT_EN
    int gaps [4] = '{11, 5, 5, 5};
    n_exp = 5;
`else
    n_exp = 1;
`endif
    cmd_ready = 1'b1;
    acc_cyc.delete();
    for (int i = 0; i < n_exp; i++) sb.push_back(3'b1_11);
    key_ascii = 8'd8;
    tick(30);
    key_ascii = 8'd0;
    wait_drain(ok);
    tick(5);
    checks++; if (!ok) begin errors++; $display("FAIL repeat_drain: got timeout, required drained"); end
    checks++;
    if (acc_cyc.size() != n_exp) begin
      errors++; $display("FAIL repeat_count: got %0d commands, required %0d", acc_cyc.size(), n_exp);
    end
`ifdef KEY_REPEAT_EN
    if (acc_cyc.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_cyc[i+1] - acc_cyc[i] != gaps[i]) begin
          errors++; $display("FAIL repeat_gap%0d: got %0d edges, required %0d", i, acc_cyc[i+1] - acc_cyc[i], gaps[i]);
        end
      end
    end
`endif
  endtask

  task automatic test_code_change_reset;
    bit ok;
    cmd_ready = 1'b0;
    key_ascii = 8'd6;
    tick(2);
    key_ascii = 8'd7;
    tick(2);
    checks++;
    if (cmd_valid !== 1'b1 || {cmd_player, cmd_dir} !== 3'b1_01) begin
      errors++; $display("FAIL change_first: got v%b p%0d d%0d, required v1 p1 d1", cmd_valid, cmd_player, cmd_dir);
    end
    rst = 1'b1;
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid0: got %b, required 0", cmd_valid); end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid1: got %b, required 0", cmd_valid); end
    sb.delete();
    rst = 1'b0;
    sb.push_back(3'b1_10);
    cmd_ready = 1'b1;
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL post_rst_e0: got valid %b, required 0", cmd_valid); end
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || {cmd_player, cmd_dir} !== 3'b1_10) begin
      errors++; $display("FAIL post_rst_cmd: got v%b p%0d d%0d, required v1 p1 d2", cmd_valid, cmd_player, cmd_dir);
    end
    tick(2);
    key_ascii = 8'd0;
    wait_drain(ok);
    tick(5);
    checks++; if (!ok) begin errors++; $display("FAIL post_rst_drain: got timeout, required drained"); end
  endtask

  initial begin
    rst = 1'b1; key_ascii = 8'd0; cmd_ready = 1'b0;
    test_reset();
    test_single_key();
    test_backpressure();
    test_overflow();
    test_repeat();
    test_code_change_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
